// File: rtl/nav_cmd_if.sv
// Command/response, sensor and drive signals between the host side and nav_cmd_proc.
interface nav_cmd_if #(
  parameter int unsigned FRWRD_W = 10,
  parameter int unsigned HEAD_W  = 12
);

  logic [15:0]              cmd;
  logic                     cmd_rdy;
  logic                     clr_cmd_rdy;
  logic                     send_resp;
  logic                     strt_cal;
  logic                     cal_done;
  logic signed [HEAD_W-1:0] heading;
  logic                     heading_rdy;
  logic                     lftIR;
  logic                     cntrIR;
  logic                     rghtIR;
  logic signed [HEAD_W-1:0] error;
  logic [FRWRD_W-1:0]       frwrd;
  logic                     moving;
  logic                     tour_go;
  logic                     fanfare_go;

  // Host / environment side: issues commands and drives sensors.
  modport master (
    output cmd, cmd_rdy, cal_done, heading, heading_rdy, lftIR, cntrIR, rghtIR,
    input  clr_cmd_rdy, send_resp, strt_cal, error, frwrd, moving, tour_go, fanfare_go
  );

  // Command processor side.
  modport slave (
    input  cmd, cmd_rdy, cal_done, heading, heading_rdy, lftIR, cntrIR, rghtIR,
    output clr_cmd_rdy, send_resp, strt_cal, error, frwrd, moving, tour_go, fanfare_go
  );

endinterface

// File: rtl/nav_cmd_proc.sv
// Navigation command processor: decodes host commands, aligns heading,
// ramps forward speed, counts square lines and decelerates to a stop.
module nav_cmd_proc #(
  parameter bit          FAST_SIM     = 1'b1,
  parameter int unsigned FRWRD_W      = 10,
  parameter int unsigned HEAD_W       = 12,
  parameter int unsigned SQ_W         = 3,
  parameter int unsigned LINES_PER_SQ = 2,
  parameter int unsigned ALIGN_TOL    = 48,
  parameter int unsigned NUDGE        = 95
) (
  input  logic       clk,
  input  logic       rst_n,
  nav_cmd_if.slave   bus
);

  localparam int unsigned LINE_W = 5;
  localparam int unsigned FW1    = FRWRD_W + 1;
  localparam int unsigned INC    = FAST_SIM ? (32'd1 << (FRWRD_W - 5)) : (32'd1 << (FRWRD_W - 8));

  localparam logic [FW1-1:0] INC_V = FW1'(INC);
  localparam logic [FW1-1:0] DEC_V = FW1'(2 * INC);

  localparam logic [HEAD_W-1:0]        NUDGE_P = HEAD_W'(NUDGE);
  localparam logic [HEAD_W-1:0]        NUDGE_N = ~NUDGE_P + HEAD_W'(1);
  localparam logic signed [HEAD_W-1:0] TOL_P   = HEAD_W'(ALIGN_TOL);
  localparam logic signed [HEAD_W-1:0] TOL_N   = -TOL_P;

  localparam logic [3:0] OPC_CAL  = 4'h0;
  localparam logic [3:0] OPC_MOVE = 4'h2;
  localparam logic [3:0] OPC_FAN  = 4'h3;
  localparam logic [3:0] OPC_TOUR = 4'h4;
  localparam logic [3:0] OPC_STOP = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAL,
    ST_ALIGN,
    ST_MOVE,
    ST_DECEL
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic                 r_clr;
  logic                 r_resp;
  logic                 r_strt;
  logic                 r_tour;
  logic                 r_fan;
  logic                 r_moving;

  logic                 w_clr_nxt;
  logic                 w_resp_nxt;
  logic                 w_strt_nxt;
  logic                 w_tour_nxt;
  logic                 w_fan_nxt;
  logic                 w_moving_nxt;
  logic                 w_load_move;
  logic                 w_latch_cmd;

  logic [3:0]           r_opc;
  logic [HEAD_W-1:0]    r_desired;
  logic [LINE_W-1:0]    r_target;
  logic [LINE_W-1:0]    r_lines;
  logic [FRWRD_W-1:0]   r_frwrd;
  logic                 r_cntr_q;

  logic [3:0]           w_opc_in;
  logic                 w_sq_zero;
  logic                 w_new_cmd;
  logic                 w_is_stop;
  logic [HEAD_W-1:0]    w_desired_in;
  logic [LINE_W-1:0]    w_target_in;
  logic [HEAD_W-1:0]    w_nudge;
  logic [HEAD_W-1:0]    w_error;
  logic                 w_aligned;
  logic                 w_cntr_rise;
  logic [FW1-1:0]       w_sum;
  logic [FW1-1:0]       w_diff;
  logic [FRWRD_W-1:0]   w_frwrd_inc;
  logic [FRWRD_W-1:0]   w_frwrd_dec;
  logic                 w_unused_cmd;

  // Command field decode; r_clr blocks re-consuming a word still held by the host.
  always_comb begin
    w_opc_in     = bus.cmd[15:12];
    w_sq_zero    = (bus.cmd[SQ_W-1:0] == '0);
    w_new_cmd    = bus.cmd_rdy && !r_clr;
    w_is_stop    = w_new_cmd && (w_opc_in == OPC_STOP);
    w_desired_in = (bus.cmd[11:4] == 8'h00) ? '0 : {bus.cmd[11:4], {(HEAD_W-8){1'b1}}};
    w_target_in  = LINE_W'(32'(bus.cmd[SQ_W-1:0]) * LINES_PER_SQ);
    w_unused_cmd = ^bus.cmd;
  end

  // Heading error with IR nudge; wraps modulo 2^HEAD_W.
  always_comb begin
    w_nudge = '0;
    if (bus.lftIR && !bus.rghtIR)
      w_nudge = NUDGE_P;
    else if (bus.rghtIR && !bus.lftIR)
      w_nudge = NUDGE_N;
    w_error   = bus.heading - r_desired + w_nudge;
    w_aligned = ($signed(w_error) > TOL_N) && ($signed(w_error) < TOL_P);
  end

  // Saturating speed ramp arithmetic; the extra MSB flags overflow/borrow.
  always_comb begin
    w_sum       = {1'b0, r_frwrd} + INC_V;
    w_diff      = {1'b0, r_frwrd} - DEC_V;
    w_frwrd_inc = w_sum[FRWRD_W]  ? '1 : w_sum[FRWRD_W-1:0];
    w_frwrd_dec = w_diff[FRWRD_W] ? '0 : w_diff[FRWRD_W-1:0];
    w_cntr_rise = bus.cntrIR && !r_cntr_q;
  end

  // Next-state and pulse decode.
  always_comb begin
    w_state_nxt = r_state;
    w_clr_nxt   = 1'b0;
    w_resp_nxt  = 1'b0;
    w_strt_nxt  = 1'b0;
    w_tour_nxt  = 1'b0;
    w_fan_nxt   = 1'b0;
    w_load_move = 1'b0;
    w_latch_cmd = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_new_cmd) begin
          w_clr_nxt   = 1'b1;
          w_latch_cmd = 1'b1;
          case (w_opc_in)
            OPC_CAL: begin
              w_strt_nxt  = 1'b1;
              w_state_nxt = ST_CAL;
            end
            OPC_MOVE, OPC_FAN: begin
              if (w_sq_zero) begin
                w_resp_nxt = 1'b1;
              end else begin
                w_load_move = 1'b1;
                w_state_nxt = ST_ALIGN;
              end
            end
            OPC_TOUR: w_tour_nxt = 1'b1;
            default:  ;
          endcase
        end
      end
      ST_CAL: begin
        if (bus.cal_done) begin
          w_resp_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ALIGN: begin
        if (w_is_stop) begin
          w_clr_nxt   = 1'b1;
          w_state_nxt = ST_DECEL;
        end else if (w_aligned) begin
          w_fan_nxt   = (r_opc == OPC_FAN);
          w_state_nxt = ST_MOVE;
        end
      end
      ST_MOVE: begin
        if (w_is_stop) begin
          w_clr_nxt   = 1'b1;
          w_state_nxt = ST_DECEL;
        end else if (r_lines == r_target) begin
          w_state_nxt = ST_DECEL;
        end
      end
      ST_DECEL: begin
        if (w_is_stop)
          w_clr_nxt = 1'b1;
        if (r_frwrd == '0) begin
          w_resp_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_moving_nxt = (w_state_nxt == ST_ALIGN) || (w_state_nxt == ST_MOVE) ||
                   (w_state_nxt == ST_DECEL);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Registered single-cycle pulses and motion flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr    <= 1'b0;
      r_resp   <= 1'b0;
      r_strt   <= 1'b0;
      r_tour   <= 1'b0;
      r_fan    <= 1'b0;
      r_moving <= 1'b0;
    end else begin
      r_clr    <= w_clr_nxt;
      r_resp   <= w_resp_nxt;
      r_strt   <= w_strt_nxt;
      r_tour   <= w_tour_nxt;
      r_fan    <= w_fan_nxt;
      r_moving <= w_moving_nxt;
    end
  end

  // Latched command fields: opcode on every consume, heading/target on move start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opc     <= 4'h0;
      r_desired <= '0;
      r_target  <= '0;
    end else begin
      if (w_latch_cmd)
        r_opc <= w_opc_in;
      if (w_load_move) begin
        r_desired <= w_desired_in;
        r_target  <= w_target_in;
      end
    end
  end

  // Centre-line edge history and line counter (counts only while moving forward).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cntr_q <= 1'b0;
      r_lines  <= '0;
    end else begin
      r_cntr_q <= bus.cntrIR;
      if (w_load_move)
        r_lines <= '0;
      else if ((r_state == ST_MOVE) && w_cntr_rise)
        r_lines <= r_lines + LINE_W'(1);
    end
  end

  // Forward speed: ramps only on heading updates, rule chosen by current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frwrd <= '0;
    end else if (bus.heading_rdy) begin
      if (r_state == ST_MOVE)
        r_frwrd <= w_frwrd_inc;
      else if (r_state == ST_DECEL)
        r_frwrd <= w_frwrd_dec;
    end
  end

  // Output drive.
  assign bus.clr_cmd_rdy = r_clr;
  assign bus.send_resp   = r_resp;
  assign bus.strt_cal    = r_strt;
  assign bus.tour_go     = r_tour;
  assign bus.fanfare_go  = r_fan;
  assign bus.moving      = r_moving;
  assign bus.frwrd       = r_frwrd;
  assign bus.error       = w_error;

endmodule

// File: tb/tb_nav_cmd_proc.sv
// Directed bench for nav_cmd_proc: calibrate, tour, move, fanfare, stop and reset.
module tb_nav_cmd_proc;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   resp_seen;

  nav_cmd_if #(.FRWRD_W(10), .HEAD_W(12)) bus ();

  nav_cmd_proc #(
    .FAST_SIM(1'b1), .FRWRD_W(10), .HEAD_W(12), .SQ_W(3),
    .LINES_PER_SQ(2), .ALIGN_TOL(48), .NUDGE(95)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue(input logic [15:0] c);
    bus.cmd     = c;
    bus.cmd_rdy = 1'b1;
    @(negedge clk);
  endtask

  task automatic hr(input int n);
    bus.heading_rdy = 1'b1;
    repeat (n) @(negedge clk);
    bus.heading_rdy = 1'b0;
  endtask

  task automatic line_edge();
    bus.cntrIR = 1'b1;
    @(negedge clk);
    bus.cntrIR = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.cmd         = 16'h0000;
    bus.cmd_rdy     = 1'b0;
    bus.cal_done    = 1'b0;
    bus.heading     = 12'sh000;
    bus.heading_rdy = 1'b0;
    bus.lftIR       = 1'b0;
    bus.cntrIR      = 1'b0;
    bus.rghtIR      = 1'b0;
    repeat (2) tick();
    chk("rst_moving", 32'(bus.moving), 32'd0);
    chk("rst_frwrd", 32'(bus.frwrd), 32'd0);
    chk("rst_clr", 32'(bus.clr_cmd_rdy), 32'd0);
    chk("rst_resp", 32'(bus.send_resp), 32'd0);
    chk("rst_strt", 32'(bus.strt_cal), 32'd0);
    rst_n = 1'b1;
    tick();

    // calibrate
    issue(16'h0000);
    chk("cal_clr", 32'(bus.clr_cmd_rdy), 32'd1);
    chk("cal_strt", 32'(bus.strt_cal), 32'd1);
    chk("cal_moving", 32'(bus.moving), 32'd0);
    bus.cmd_rdy = 1'b0;
    tick();
    chk("cal_clr_off", 32'(bus.clr_cmd_rdy), 32'd0);
    chk("cal_strt_off", 32'(bus.strt_cal), 32'd0);
    resp_seen = 0;
    repeat (100) begin
      tick();
      if (bus.send_resp) resp_seen++;
    end
    chk("cal_no_early_resp", 32'(resp_seen), 32'd0);
    bus.cal_done = 1'b1;
    tick();
    chk("cal_resp", 32'(bus.send_resp), 32'd1);
    bus.cal_done = 1'b0;
    tick();
    chk("cal_resp_off", 32'(bus.send_resp), 32'd0);

    // tour
    issue(16'h4000);
    chk("tour_go", 32'(bus.tour_go), 32'd1);
    chk("tour_clr", 32'(bus.clr_cmd_rdy), 32'd1);
    chk("tour_no_resp", 32'(bus.send_resp), 32'd0);
    bus.cmd_rdy = 1'b0;
    tick();
    chk("tour_go_off", 32'(bus.tour_go), 32'd0);
    chk("tour_no_resp2", 32'(bus.send_resp), 32'd0);
    chk("tour_idle", 32'(bus.moving), 32'd0);

    // move with zero squares
    issue(16'h2000);
    chk("mv0_resp", 32'(bus.send_resp), 32'd1);
    chk("mv0_clr", 32'(bus.clr_cmd_rdy), 32'd1);
    chk("mv0_moving", 32'(bus.moving), 32'd0);
    bus.cmd_rdy = 1'b0;
    tick();
    chk("mv0_resp_off", 32'(bus.send_resp), 32'd0);
    chk("mv0_moving2", 32'(bus.moving), 32'd0);
    chk("mv0_frwrd", 32'(bus.frwrd), 32'd0);

    // discarded opcodes, including stop while idle
    issue(16'h1234);
    chk("bad_clr", 32'(bus.clr_cmd_rdy), 32'd1);
    chk("bad_resp", 32'(bus.send_resp), 32'd0);
    chk("bad_moving", 32'(bus.moving), 32'd0);
    bus.cmd_rdy = 1'b0;
    tick();
    issue(16'hF000);
    chk("idle_stop_clr", 32'(bus.clr_cmd_rdy), 32'd1);
    chk("idle_stop_moving", 32'(bus.moving), 32'd0);
    chk("idle_stop_resp", 32'(bus.send_resp), 32'd0);
    bus.cmd_rdy = 1'b0;
    tick();

    // move two squares, heading already aligned
    bus.heading = 12'sh000;
    issue(16'h2002);
    chk("mv_clr", 32'(bus.clr_cmd_rdy), 32'd1);
    chk("mv_moving", 32'(bus.moving), 32'd1);
    chk("mv_error", {20'd0, bus.error}, 32'h000);
    chk("mv_frwrd0", 32'(bus.frwrd), 32'd0);
    bus.cmd_rdy = 1'b0;
    tick();
    chk("mv_no_fanfare", 32'(bus.fanfare_go), 32'd0);
    hr(1);
    chk("ramp_1", 32'(bus.frwrd), 32'd32);
    hr(1);
    chk("ramp_2", 32'(bus.frwrd), 32'd64);
    hr(29);
    chk("ramp_31", 32'(bus.frwrd), 32'd992);
    hr(1);
    chk("ramp_sat", 32'(bus.frwrd), 32'd1023);
    hr(2);
    chk("ramp_sat_hold", 32'(bus.frwrd), 32'd1023);
    bus.lftIR = 1'b1;
    #1;
    chk("nudge_left", {20'd0, bus.error}, 32'h05F);
    bus.rghtIR = 1'b1;
    #1;
    chk("nudge_both", {20'd0, bus.error}, 32'h000);
    bus.lftIR = 1'b0;
    #1;
    chk("nudge_right", {20'd0, bus.error}, 32'hFA1);
    bus.rghtIR = 1'b0;
    repeat (3) line_edge();
    hr(1);
    chk("three_lines_still_move", 32'(bus.frwrd), 32'd1023);
    chk("three_lines_moving", 32'(bus.moving), 32'd1);
    line_edge();
    hr(1);
    chk("decel_1", 32'(bus.frwrd), 32'd959);
    hr(14);
    chk("decel_15", 32'(bus.frwrd), 32'd63);
    chk("decel_no_resp", 32'(bus.send_resp), 32'd0);
    hr(1);
    chk("decel_sat0", 32'(bus.frwrd), 32'd0);
    chk("decel_resp_wait", 32'(bus.send_resp), 32'd0);
    tick();
    chk("decel_resp", 32'(bus.send_resp), 32'd1);
    chk("decel_idle", 32'(bus.moving), 32'd0);
    tick();
    chk("decel_resp_off", 32'(bus.send_resp), 32'd0);

    // fanfare move: heading must come into tolerance first
    bus.heading = 12'sh000;
    issue(16'h37F1);
    chk("fan_clr", 32'(bus.clr_cmd_rdy), 32'd1);
    chk("fan_moving", 32'(bus.moving), 32'd1);
    chk("fan_err_far", {20'd0, bus.error}, 32'h801);
    bus.cmd_rdy = 1'b0;
    tick();
    chk("fan_wait", 32'(bus.fanfare_go), 32'd0);
    hr(1);
    chk("align_hold_frwrd", 32'(bus.frwrd), 32'd0);
    bus.heading = 12'sh7CF;
    #1;
    chk("fan_err_edge", {20'd0, bus.error}, 32'hFD0);
    tick();
    tick();
    chk("fan_edge_no_go", 32'(bus.fanfare_go), 32'd0);
    hr(1);
    chk("align_edge_frwrd", 32'(bus.frwrd), 32'd0);
    bus.heading = 12'sh7E0;
    #1;
    chk("fan_err_near", {20'd0, bus.error}, 32'hFE1);
    tick();
    chk("fan_go", 32'(bus.fanfare_go), 32'd1);
    tick();
    chk("fan_go_off", 32'(bus.fanfare_go), 32'd0);
    hr(3);
    chk("fan_ramp", 32'(bus.frwrd), 32'd96);

    // stop mid-move
    issue(16'hF000);
    chk("stop_clr", 32'(bus.clr_cmd_rdy), 32'd1);
    chk("stop_moving", 32'(bus.moving), 32'd1);
    bus.cmd_rdy = 1'b0;
    hr(1);
    chk("stop_decel_1", 32'(bus.frwrd), 32'd32);
    hr(1);
    chk("stop_decel_0", 32'(bus.frwrd), 32'd0);
    chk("stop_resp_wait", 32'(bus.send_resp), 32'd0);
    tick();
    chk("stop_resp", 32'(bus.send_resp), 32'd1);
    chk("stop_idle", 32'(bus.moving), 32'd0);
    tick();
    chk("stop_resp_off", 32'(bus.send_resp), 32'd0);

    // non-stop command pends while busy; stop in ALIGN ends at once
    bus.heading = 12'sh000;
    issue(16'h37F1);
    chk("pend_setup_clr", 32'(bus.clr_cmd_rdy), 32'd1);
    bus.cmd_rdy = 1'b0;
    tick();
    bus.cmd     = 16'h4000;
    bus.cmd_rdy = 1'b1;
    tick();
    tick();
    chk("pend_no_clr", 32'(bus.clr_cmd_rdy), 32'd0);
    chk("pend_no_tour", 32'(bus.tour_go), 32'd0);
    bus.cmd = 16'hF000;
    tick();
    chk("align_stop_clr", 32'(bus.clr_cmd_rdy), 32'd1);
    chk("align_stop_moving", 32'(bus.moving), 32'd1);
    chk("align_stop_no_resp", 32'(bus.send_resp), 32'd0);
    bus.cmd_rdy = 1'b0;
    tick();
    chk("align_stop_resp", 32'(bus.send_resp), 32'd1);
    chk("align_stop_idle", 32'(bus.moving), 32'd0);
    tick();
    chk("align_stop_resp_off", 32'(bus.send_resp), 32'd0);

    // asynchronous reset mid-move
    issue(16'h2002);
    bus.cmd_rdy = 1'b0;
    tick();
    hr(2);
    chk("pre_rst_frwrd", 32'(bus.frwrd), 32'd64);
    chk("pre_rst_moving", 32'(bus.moving), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_frwrd", 32'(bus.frwrd), 32'd0);
    chk("rst_mid_moving", 32'(bus.moving), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_moving", 32'(bus.moving), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
